// File: rtl/dcf_frame_sequencer.sv
// DCF77 frame sequencer: plays a 59-bit frame as 100/200 ms amplitude pulses, second 59 as minute marker.
// Optional define DCF_FRAME_PARITY_CHECK_EN rejects offered frames failing the DCF framing/parity rules.
module dcf_frame_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 1300000,
  parameter int unsigned SHORT_TICKS   = 130000,
  parameter int unsigned LONG_TICKS    = 260000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [58:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        pulse,
  output logic [5:0]  bit_index,
  output logic        second_tick,
  output logic        minute_start,
  output logic        underrun,
  output logic        frame_error
);

  localparam int unsigned   PW        = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] SHORT_T   = PW'(SHORT_TICKS);
  localparam logic [PW-1:0] LONG_T    = PW'(LONG_TICKS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, MARK} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    bit_q, bit_d;
  logic [58:0]   active_q, active_d;
  logic [58:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          underrun_q, underrun_d;
  logic          handshake, frame_ok, accept, last_tick;

`ifdef DCF_FRAME_PARITY_CHECK_EN
  logic frame_error_q;

  assign frame_ok = !frame_data[0] && frame_data[20] && !(^frame_data[28:21]) &&
                    !(^frame_data[35:29]) && !(^frame_data[58:36]);

  always_ff @(posedge clock) begin
    if (reset) frame_error_q <= 1'b0;
    else       frame_error_q <= handshake && !frame_ok;
  end

  assign frame_error = frame_error_q;
`else
  assign frame_ok    = 1'b1;
  assign frame_error = 1'b0;
`endif

  assign frame_ready  = (state_q == LOAD) || ((state_q == MARK) && !pend_vld_q);
  assign handshake    = frame_valid && frame_ready;
  assign accept       = handshake && frame_ok;
  assign last_tick    = (presc_q == LAST_TICK);
  assign pulse        = (state_q == RUN) &&
                        (active_q[bit_q] ? (presc_q < LONG_T) : (presc_q < SHORT_T));
  assign second_tick  = ((state_q == RUN) || (state_q == MARK)) && (presc_q == '0);
  assign minute_start = second_tick && (bit_q == 6'd0);
  assign bit_index    = bit_q;
  assign underrun     = underrun_q;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    bit_d      = bit_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        bit_d   = 6'd0;
        state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          active_d = frame_data;
          presc_d  = '0;
          bit_d    = 6'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (last_tick) begin
          presc_d = '0;
          bit_d   = bit_q + 6'd1;
          if (bit_q == 6'd58) state_d = MARK;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      MARK: begin
        if (accept) begin
          pend_d     = frame_data;
          pend_vld_d = 1'b1;
        end
        if (last_tick) begin
          // A frame handshaken on this very cycle goes straight to active.
          presc_d    = '0;
          bit_d      = 6'd0;
          state_d    = RUN;
          pend_vld_d = 1'b0;
          if (pend_vld_q)  active_d   = pend_q;
          else if (accept) active_d   = frame_data;
          else             underrun_d = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d    = IDLE;
      presc_d    = '0;
      bit_d      = 6'd0;
      pend_vld_d = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      bit_q      <= 6'd0;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      bit_q      <= bit_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_dcf_frame_sequencer.sv
// Directed bench for dcf_frame_sequencer with 20-tick seconds, 2/4-tick pulses.
module tb_dcf_frame_sequencer;

  localparam int TPS = 20;
  localparam int SHT = 2;
  localparam int LNG = 4;

  logic        clock = 1'b0;
  logic        reset, enable, frame_valid;
  logic [58:0] frame_data;
  logic        frame_ready, pulse, second_tick, minute_start, underrun, frame_error;
  logic [5:0]  bit_index;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_secs;

  logic [58:0] fa, fb, fbad;

  dcf_frame_sequencer #(.TICKS_PER_SEC(TPS), .SHORT_TICKS(SHT), .LONG_TICKS(LNG)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .pulse(pulse), .bit_index(bit_index), .second_tick(second_tick),
    .minute_start(minute_start), .underrun(underrun), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the first cycle of a RUN second; leaves on the first cycle of the next.
  task automatic run_second(input logic [58:0] fr, input int sec);
    int cnt, exp_hi;
    logic prefix, rdy;
    exp_hi = fr[sec] ? LNG : SHT;
    cnt = 0; prefix = 1'b1; rdy = 1'b0;
    chk("sec_index", 64'(bit_index), 64'(sec));
    chk("sec_tick", 64'(second_tick), 64'd1);
    chk("sec_minute_start", 64'(minute_start), 64'(sec == 0));
    for (int i = 0; i < TPS; i++) begin
      if (pulse) cnt++;
      if (pulse !== (i < cnt + 1 && cnt == i + 1)) prefix = 1'b0;
      if (frame_ready) rdy = 1'b1;
      if (i == 1) chk("underrun_clear", 64'(underrun), 64'd0);
      step();
    end
    if (cnt > 0) pulse_secs++;
    chk("pulse_len", 64'(cnt), 64'(exp_hi));
    chk("pulse_leading", 64'(prefix), 64'd1);
    chk("ready_in_run", 64'(rdy), 64'd0);
  endtask

  task automatic run_minute(input logic [58:0] fr);
    pulse_secs = 0;
    for (int s = 0; s < 59; s++) run_second(fr, s);
    chk("pulses_per_min", 64'(pulse_secs), 64'd59);
  endtask

  // Minute marker second; offer_at < 0 offers nothing.
  task automatic mark_second(input int offer_at, input logic [58:0] fr);
    int hi;
    hi = 0;
    chk("mark_index", 64'(bit_index), 64'd59);
    chk("mark_ready", 64'(frame_ready), 64'd1);
    chk("mark_tick", 64'(second_tick), 64'd1);
    chk("mark_minute_start", 64'(minute_start), 64'd0);
    for (int i = 0; i < TPS; i++) begin
      if (pulse) hi++;
      if (i == offer_at) begin
        frame_valid = 1'b1;
        frame_data  = fr;
        chk("mark_offer_ready", 64'(frame_ready), 64'd1);
      end
      step();
      frame_valid = 1'b0;
      if (i == offer_at && i < TPS - 1) chk("mark_ready_drop", 64'(frame_ready), 64'd0);
    end
    chk("mark_pulse_cycles", 64'(hi), 64'd0);
  endtask

  initial begin
    fa = '0; fa[1] = 1'b1; fa[20] = 1'b1;
    fb = '0; fb[2] = 1'b1; fb[20] = 1'b1; fb[21] = 1'b1; fb[22] = 1'b1;
    fbad = fa; fbad[28] = ~fbad[28];
    reset = 1'b1; enable = 1'b0; frame_valid = 1'b0; frame_data = '0;
    step(); step();
    chk("rst_pulse", 64'(pulse), 64'd0);
    chk("rst_index", 64'(bit_index), 64'd0);
    chk("rst_ready", 64'(frame_ready), 64'd0);
    chk("rst_tick", 64'(second_tick), 64'd0);
    chk("rst_minute", 64'(minute_start), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_ferr", 64'(frame_error), 64'd0);

    reset = 1'b0; enable = 1'b1;
    step();
    chk("load_ready", 64'(frame_ready), 64'd1);
    frame_valid = 1'b1; frame_data = fa;
    step();
    frame_valid = 1'b0;
    chk("first_pulse", 64'(pulse), 64'd1);
    chk("first_minute_start", 64'(minute_start), 64'd1);
    chk("first_ferr", 64'(frame_error), 64'd0);
    run_minute(fa);

    // No frame during the marker: underrun, then the old pattern repeats.
    mark_second(-1, fb);
    chk("underrun_set", 64'(underrun), 64'd1);
    run_minute(fa);

    // Frame arrives on the last marker cycle.
    mark_second(TPS - 1, fb);
    chk("late_no_underrun", 64'(underrun), 64'd0);
    run_minute(fb);

    mark_second(3, fa);
    chk("early_no_underrun", 64'(underrun), 64'd0);
    run_second(fa, 0);
    step();
    chk("long_pulse_c1", 64'(pulse), 64'd1);
    enable = 1'b0;
    step();
    chk("dis_pulse", 64'(pulse), 64'd0);
    chk("dis_index", 64'(bit_index), 64'd0);
    chk("dis_ready", 64'(frame_ready), 64'd0);
    chk("dis_tick", 64'(second_tick), 64'd0);
    step();
    chk("idle_pulse", 64'(pulse), 64'd0);

    enable = 1'b1;
    step();
    chk("reload_ready", 64'(frame_ready), 64'd1);
    chk("reload_index", 64'(bit_index), 64'd0);
`ifdef DCF_FRAME_PARITY_CHECK_EN
    frame_valid = 1'b1; frame_data = fbad;
    step();
    frame_valid = 1'b0;
    chk("bad_ferr", 64'(frame_error), 64'd1);
    chk("bad_still_load", 64'(frame_ready), 64'd1);
    chk("bad_no_tick", 64'(second_tick), 64'd0);
    step();
    chk("bad_ferr_clear", 64'(frame_error), 64'd0);
    chk("bad_ready_hold", 64'(frame_ready), 64'd1);
`endif
    frame_valid = 1'b1; frame_data = fb;
    step();
    frame_valid = 1'b0;
    chk("restart_minute", 64'(minute_start), 64'd1);
    chk("restart_pulse", 64'(pulse), 64'd1);
    chk("restart_ferr", 64'(frame_error), 64'd0);
    run_second(fb, 0);
    run_second(fb, 1);
    step();
    chk("pre_reset_pulse", 64'(pulse), 64'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_pulse", 64'(pulse), 64'd0);
    chk("mid_rst_index", 64'(bit_index), 64'd0);
    chk("mid_rst_ready", 64'(frame_ready), 64'd0);
    chk("mid_rst_tick", 64'(second_tick), 64'd0);
    chk("mid_rst_minute", 64'(minute_start), 64'd0);
    chk("mid_rst_underrun", 64'(underrun), 64'd0);
    chk("mid_rst_ferr", 64'(frame_error), 64'd0);
    reset = 1'b0; enable = 1'b0;
    step();
    chk("post_rst_pulse", 64'(pulse), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcf_frame_sequencer.md
DCF_FRAME_SEQUENCER -- requirements
Module: dcf_frame_sequencer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 1300000: clock cycles per DCF second, legal range 8..2097151.
REQ-002 The block SHALL have parameter SHORT_TICKS, default 130000: length of a "0" pulse (100 ms).
REQ-003 The block SHALL have parameter LONG_TICKS, default 260000: length of a "1" pulse (200 ms); legal only if SHORT_TICKS < LONG_TICKS < TICKS_PER_SEC.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: transmission enable.
REQ-007 The block SHALL have port frame_data, input, 59 bits: frame_data[n] is DCF second n.
REQ-008 The block SHALL have port frame_valid, input, 1 bit: frame_data is valid.
REQ-009 The block SHALL have port frame_ready, output, 1 bit: the sequencer accepts frame_data this cycle.
REQ-010 The block SHALL have port pulse, output, 1 bit: 1 = carrier amplitude reduced; this is the pulse input of the signal generator.
REQ-011 The block SHALL have port bit_index, output, 6 bits: current second, 0..59.
REQ-012 The block SHALL have port second_tick, output, 1 bit: one-cycle strobe at the start of each second.
REQ-013 The block SHALL have port minute_start, output, 1 bit: one-cycle strobe at the start of second 0.
REQ-014 The block SHALL have port underrun, output, 1 bit: one-cycle strobe when a minute boundary passes with no new frame.
REQ-015 The block SHALL have port frame_error, output, 1 bit: one-cycle strobe when an offered frame is rejected.

Function
REQ-016 The block SHALL implement state machine IDLE, LOAD, RUN (seconds 0..58) and MARK (second 59), driven by a prescaler (0..TICKS_PER_SEC-1) and bit_index; all state is registered.
REQ-017 In IDLE the block SHALL hold pulse=0, prescaler=0 and bit_index=0; enable=1 SHALL cause IDLE->LOAD on the next cycle.
REQ-018 In LOAD, frame_ready SHALL be 1; a transfer SHALL occur when frame_valid && frame_ready; an accepted frame SHALL be latched to the active register, with the next cycle in RUN, prescaler=0, bit_index=0.
REQ-019 In RUN the block SHALL drive pulse = (prescaler < LONG_TICKS) when active[bit_index]=1, else (prescaler < SHORT_TICKS), so the pulse begins in the first cycle of the second.
REQ-020 The block SHALL assert second_tick in every RUN/MARK cycle with prescaler=0, and minute_start additionally when bit_index=0.
REQ-021 At prescaler=TICKS_PER_SEC-1 the block SHALL wrap the prescaler to 0 and increment bit_index; 58->59 SHALL enter MARK.
REQ-022 In MARK the block SHALL hold pulse=0 for the whole second (minute marker) and assert frame_ready until one frame is accepted into a pending register; after acceptance frame_ready SHALL drop.
REQ-023 At the end of MARK the block SHALL set bit_index to 0 and enter RUN; if a pending frame exists it SHALL become active, otherwise the block SHALL pulse underrun for one cycle and re-send the previous frame unchanged.
REQ-024 A handshake on the final MARK cycle SHALL count as pending, so no underrun occurs.
REQ-025 In RUN, frame_ready SHALL be 0 and frame_data SHALL be ignored.
REQ-026 In any state, enable=0 SHALL force IDLE on the next cycle, with pulse=0 that cycle and the pending frame discarded.
REQ-027 A re-enable SHALL restart from LOAD and never resume mid-minute.

Reset
REQ-028 reset=1 at a clock edge SHALL, with priority over all inputs, give: state IDLE, prescaler 0, bit_index 0, active and pending frames 0, pending flag 0, all outputs 0.
REQ-029 Reset asserted mid-pulse SHALL drive pulse=0 in the following cycle.

Configuration
REQ-030 With macro DCF_FRAME_PARITY_CHECK_EN defined, the block SHALL accept an offered frame only if bit0=0, bit20=1, and even parity holds over bits 21..28, 29..35 and 36..58.
REQ-031 With DCF_FRAME_PARITY_CHECK_EN defined, on a failed check the handshake SHALL still complete (frame consumed), the frame SHALL be discarded, frame_error SHALL pulse one cycle, and the state SHALL be unchanged: LOAD stays LOAD, and in MARK frame_ready stays 1.
REQ-032 Without DCF_FRAME_PARITY_CHECK_EN, every offered frame SHALL be accepted and frame_error SHALL be tied to 0.

Verification
Bench parameters: TICKS_PER_SEC=20, SHORT_TICKS=2, LONG_TICKS=4.
REQ-033 The bench SHALL cover: reset, enable=1, one frame with bit0=0, bit1=1 -> pulse high for 2 cycles in second 0 and 4 cycles in second 1; minute_start coincides with the first pulse cycle.
REQ-034 The bench SHALL cover: full minute -> 59 pulses, second 59 with pulse=0 for 20 cycles, frame_ready=1 only in LOAD/MARK.
REQ-035 The bench SHALL cover: no frame offered during MARK -> underrun=1 for one cycle at the boundary, and second 0 repeats the old bit pattern.
REQ-036 The bench SHALL cover: frame_valid rising on the last MARK cycle -> accepted, no underrun, new bits sent from second 0.
REQ-037 The bench SHALL cover: enable=0 during cycle 1 of a LONG pulse -> pulse=0 next cycle, state IDLE; reset mid-minute -> all outputs 0.
REQ-038 The bench SHALL cover, with DCF_FRAME_PARITY_CHECK_EN defined: frame with bit 28 flipped -> frame_error=1 for one cycle, no state change; a corrected frame is then accepted.
